// File: rtl/clk_ctrl_pkg.sv
// Shared types and widths for the core clock run/halt/step controller.
package clk_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } clk_state_e;

  localparam int CYCLE_CNT_W = 32;
  localparam int STEP_CNT_W  = 8;

  // A zero step request still issues one enable.
  function automatic logic [STEP_CNT_W-1:0] step_load(input logic [STEP_CNT_W-1:0] cnt);
    return (cnt == '0) ? STEP_CNT_W'(1) : cnt;
  endfunction
endpackage

// File: rtl/clk_en_divider.sv
// Clock-enable divider: one enable every div+1 active cycles, divisor latched on entry.
module clk_en_divider #(
  parameter int DivWidth = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iLoad,
  input  logic                iActive,
  input  logic [DivWidth-1:0] iDiv,
  output logic                oClkEn
);
  logic [DivWidth-1:0] div_cnt_q, div_cnt_d;
  logic [DivWidth-1:0] div_lat_q, div_lat_d;
  logic                clk_en;

  // Decoded from flops only so the core sees no input-to-enable path.
  assign clk_en = iActive && (div_cnt_q == div_lat_q);
  assign oClkEn = clk_en;

  always_comb begin
    div_cnt_d = div_cnt_q;
    div_lat_d = div_lat_q;
    if (iLoad) begin
      div_cnt_d = '0;
      div_lat_d = iDiv;
    end else if (clk_en) begin
      div_cnt_d = '0;
    end else if (iActive) begin
      div_cnt_d = div_cnt_q + DivWidth'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      div_cnt_q <= '0;
      div_lat_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_lat_q <= div_lat_d;
    end
  end
endmodule

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step controller: post-reset core hold, then divided clock
// enables either free-running or as bounded step bursts.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int ResetHoldCycles = 16,
  parameter int DivWidth        = 8
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iRun,
  input  logic                   iStep,
  input  logic [STEP_CNT_W-1:0]  iStepCount,
  input  logic [DivWidth-1:0]    iDiv,
  output logic                   oCoreRst,
  output logic                   oClkEn,
  output logic                   oStepDone,
  output logic [1:0]             oState,
  output logic [CYCLE_CNT_W-1:0] oCycleCount
);
  localparam int HOLD_W = $clog2(ResetHoldCycles + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ResetHoldCycles - 1);

  clk_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STEP_CNT_W-1:0]  step_remain_q, step_remain_d;
  logic                   step_done_q, step_done_d;
  logic [CYCLE_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                   div_load;
  logic                   clk_en;

  clk_en_divider #(.DivWidth(DivWidth)) u_div (
    .iClk    (iClk),
    .iRst    (iRst),
    .iLoad   (div_load),
    .iActive ((state_q == ST_RUN) || (state_q == ST_STEP)),
    .iDiv    (iDiv),
    .oClkEn  (clk_en)
  );

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    step_remain_d = step_remain_q;
    step_done_d   = 1'b0;
    div_load      = 1'b0;
    cycle_cnt_d   = clk_en ? cycle_cnt_q + CYCLE_CNT_W'(1) : cycle_cnt_q;
    unique case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_HALT;
          hold_cnt_d = '0;
        end
      end
      ST_HALT: begin
        if (iRun) begin
          state_d  = ST_RUN;
          div_load = 1'b1;
        end else if (iStep) begin
          state_d       = ST_STEP;
          div_load      = 1'b1;
          step_remain_d = step_load(iStepCount);
        end
      end
      ST_RUN: begin
        if (!iRun) state_d = ST_HALT;
      end
      ST_STEP: begin
        // iRun is deliberately not looked at: a burst always runs to completion.
        if (clk_en) begin
          if (step_remain_q == STEP_CNT_W'(1)) begin
            state_d     = ST_HALT;
            step_done_d = 1'b1;
          end else begin
            step_remain_d = step_remain_q - STEP_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      step_remain_q <= '0;
      step_done_q   <= 1'b0;
      cycle_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      step_remain_q <= step_remain_d;
      step_done_q   <= step_done_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign oCoreRst    = (state_q == ST_HOLD);
  assign oClkEn      = clk_en;
  assign oStepDone   = step_done_q;
  assign oState      = state_q;
  assign oCycleCount = cycle_cnt_q;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: randomized run/step scenarios against an arithmetic
// model of enable positions, burst length and pulse count.
module tb_clk_step_ctrl;
  logic        iClk = 1'b0;
  logic        iRst;
  logic        iRun;
  logic        iStep;
  logic [7:0]  iStepCount;
  logic [7:0]  iDiv;
  logic        oCoreRst;
  logic        oClkEn;
  logic        oStepDone;
  logic [1:0]  oState;
  logic [31:0] oCycleCount;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_cnt = 0;

  clk_step_ctrl #(.ResetHoldCycles(16), .DivWidth(8)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iRun        (iRun),
    .iStep       (iStep),
    .iStepCount  (iStepCount),
    .iDiv        (iDiv),
    .oCoreRst    (oCoreRst),
    .oClkEn      (oClkEn),
    .oStepDone   (oStepDone),
    .oState      (oState),
    .oCycleCount (oCycleCount)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Releases reset and measures how long the core is held.
  task automatic release_and_hold(input string tag);
    int n;
    int seen_done;
    n = 0;
    seen_done = 0;
    iRst = 1'b0;
    for (int i = 0; i < 40 && oCoreRst; i++) begin
      vectors++;
      if (oClkEn !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_hold_en: oClkEn=%b required 0 (cycle %0d)", tag, oClkEn, i);
      end
      if (oStepDone) seen_done++;
      n++;
      tick();
    end
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL %s_hold_len: oCoreRst high %0d cycles required 16", tag, n);
    end
    vectors++;
    if (oState !== 2'd1) begin
      miscompares++;
      $display("FAIL %s_after_hold: oState=%0d required 1", tag, oState);
    end
    vectors++;
    if (seen_done !== 0) begin
      miscompares++;
      $display("FAIL %s_hold_done: oStepDone seen %0d times required 0", tag, seen_done);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iRun = 1'b0; iStep = 1'b0; iStepCount = 8'd0; iDiv = 8'd0;
    repeat (3) tick();
    vectors++;
    if ({oCoreRst, oClkEn, oStepDone, oState} !== 5'b1_0_0_00) begin
      miscompares++;
      $display("FAIL reset_outputs: rst/en/done/state=%b%b%b%0d required 1000", oCoreRst, oClkEn, oStepDone, oState);
    end
    vectors++;
    if (oCycleCount !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_count: oCycleCount=%0d required 0", oCycleCount);
    end
    release_and_hold("reset");
    exp_cnt = 0;
  endtask

  // Run window of len cycles: enables land on offsets k with k mod (d+1) == d.
  task automatic run_free(input int d, input int len);
    iDiv = 8'(d);
    iRun = 1'b1;
    tick();
    for (int k = 0; k < len; k++) begin
      vectors++;
      if (oClkEn !== ((k % (d + 1)) == d)) begin
        miscompares++;
        $display("FAIL run_en d=%0d k=%0d: oClkEn=%b required %b", d, k, oClkEn, (k % (d + 1)) == d);
      end
      vectors++;
      if (oState !== 2'd2) begin
        miscompares++;
        $display("FAIL run_state d=%0d k=%0d: oState=%0d required 2", d, k, oState);
      end
      iDiv = 8'($urandom);
      iStep = 1'($urandom_range(0, 1));
      iStepCount = 8'($urandom);
      if (k == len - 1) iRun = 1'b0;
      tick();
    end
    iStep = 1'b0;
    exp_cnt += 32'(len / (d + 1));
    vectors++;
    if (oState !== 2'd1 || oClkEn !== 1'b0) begin
      miscompares++;
      $display("FAIL run_stop d=%0d: oState=%0d oClkEn=%b required 1 and 0", d, oState, oClkEn);
    end
    vectors++;
    if (oCycleCount !== exp_cnt) begin
      miscompares++;
      $display("FAIL run_count d=%0d len=%0d: oCycleCount=%0d required %0d", d, len, oCycleCount, exp_cnt);
    end
    tick();
  endtask

  task automatic test_free_run();
    run_free(0, 10);
    for (int i = 0; i < 5; i++)
      run_free($urandom_range(0, 4), $urandom_range(1, 20));
  endtask

  // Burst of n enables at divider d: STEP lasts n*(d+1) cycles, done on the next.
  task automatic run_step(input int cnt, input int d, input bit noise);
    int n;
    int len;
    n = (cnt == 0) ? 1 : cnt;
    len = n * (d + 1);
    iStepCount = 8'(cnt);
    iDiv = 8'(d);
    iStep = 1'b1;
    tick();
    iStep = 1'b0;
    for (int k = 0; k < len + 2; k++) begin
      vectors++;
      if (oClkEn !== (k < len && (k % (d + 1)) == d)) begin
        miscompares++;
        $display("FAIL step_en n=%0d d=%0d k=%0d: oClkEn=%b required %b", n, d, k, oClkEn, k < len && (k % (d + 1)) == d);
      end
      vectors++;
      if (oStepDone !== (k == len)) begin
        miscompares++;
        $display("FAIL step_done n=%0d d=%0d k=%0d: oStepDone=%b required %b", n, d, k, oStepDone, k == len);
      end
      vectors++;
      if (oState !== ((k < len) ? 2'd3 : 2'd1)) begin
        miscompares++;
        $display("FAIL step_state n=%0d d=%0d k=%0d: oState=%0d required %0d", n, d, k, oState, (k < len) ? 3 : 1);
      end
      if (noise && k < len) begin
        iStep = 1'($urandom_range(0, 1));
        iDiv = 8'($urandom);
        iStepCount = 8'($urandom);
      end else begin
        iStep = 1'b0;
      end
      tick();
    end
    exp_cnt += 32'(n);
    vectors++;
    if (oCycleCount !== exp_cnt) begin
      miscompares++;
      $display("FAIL step_count n=%0d d=%0d: oCycleCount=%0d required %0d", n, d, oCycleCount, exp_cnt);
    end
  endtask

  task automatic test_step();
    run_step(3, 2, 1'b0);
    run_step(0, 1, 1'b1);
    run_step(0, 0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_step($urandom_range(1, 8), $urandom_range(0, 5), 1'b1);
  endtask

  task automatic test_reset_abort();
    int ens;
    ens = 0;
    iStepCount = 8'd4;
    iDiv = 8'd2;
    iStep = 1'b1;
    tick();
    iStep = 1'b0;
    for (int k = 0; k < 20 && ens == 0; k++) begin
      if (oClkEn) ens++;
      else tick();
    end
    vectors++;
    if (ens !== 1) begin
      miscompares++;
      $display("FAIL abort_first_en: saw %0d enables required 1", ens);
    end
    iRst = 1'b1;
    tick();
    vectors++;
    if ({oCoreRst, oClkEn, oStepDone, oState} !== 5'b1_0_0_00 || oCycleCount !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_reset: rst/en/done/state=%b%b%b%0d count=%0d required 1000 count 0", oCoreRst, oClkEn, oStepDone, oState, oCycleCount);
    end
    release_and_hold("abort");
    exp_cnt = 0;
    vectors++;
    if (oCycleCount !== 32'd0 || oStepDone !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_after: count=%0d done=%b required 0 and 0", oCycleCount, oStepDone);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0;
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #2;
    release dut.cycle_cnt_q;
    tick();
    iDiv = 8'd0;
    iRun = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (oCycleCount !== want[k] || oClkEn !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap k=%0d: oCycleCount=%h oClkEn=%b required %h and 1", k, oCycleCount, oClkEn, want[k]);
      end
      if (k == 2) iRun = 1'b0;
      tick();
    end
    vectors++;
    if (oCycleCount !== 32'd1 || oState !== 2'd1) begin
      miscompares++;
      $display("FAIL wrap_end: oCycleCount=%h oState=%0d required 00000001 and 1", oCycleCount, oState);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_reset_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Run/halt/single-step controller for the processor core clock. Sequences post-reset hold of the core, then issues a one-cycle clock-enable qualifier (`oClkEn`) that the core uses instead of a gated clock, at a programmable divided rate, either free-running or for a bounded number of cycles per step request. Sits between the board/testbench clock source and the core, and drives the core's reset and clock enable.

## Interface
- `ResetHoldCycles`, 16: cycles `oCoreRst` stays high after `iRst` release; legal range is ≥1.
- `DivWidth`, 8: width of the enable divider.
- `iClk`  in  1  system clock; single clock domain.
- `iRst`  in  1  reset; synchronous, active-high.
- `iRun`  in  1  level; high requests free-running enables.
- `iStep`  in  1  pulse; requests one step burst when halted.
- `iStepCount`  in  8  enables per step; 0 is treated as 1.
- `iDiv`  in  DivWidth  enable spacing; one `oClkEn` every `iDiv+1` cycles.
- `oCoreRst`  out  1  core reset; high while in HOLD.
- `oClkEn`  out  1  core clock-enable qualifier, one cycle wide.
- `oStepDone`  out  1  one-cycle pulse when a step burst completes.
- `oState`  out  2  encoding: HOLD=0, HALT=1, RUN=2, STEP=3.
- `oCycleCount`  out  32  number of `oClkEn` pulses since reset; wraps.

## Operation
- States:
  - HOLD: hold counter increments each cycle. Goes to HALT on the cycle `holdCnt == ResetHoldCycles-1`.
  - HALT: if `iRun` is high, go to RUN. Otherwise, if `iStep` is high, go to STEP and load `stepRemain = max(iStepCount,1)`. `iRun` has priority over `iStep`.
  - RUN: `iRun` low at any edge goes to HALT. A pending divider count is discarded.
  - STEP: on an `oClkEn` with `stepRemain==1`, go to HALT and set `oStepDone` in the next cycle. Otherwise `stepRemain` decrements on each `oClkEn`.
- `iStep` is ignored in HOLD, RUN and STEP; it is not queued.
- `iRun` rising during STEP does not abort the burst. The burst completes, the block enters HALT for one cycle, then goes to RUN if `iRun` is still high.
- Divider:
  - Entering RUN or STEP clears `divCnt` to 0 and latches `iDiv` into `divLat`. Changes to `iDiv` while in RUN or STEP have no effect until the next entry.
  - `oClkEn = (state==RUN || state==STEP) && divCnt==divLat`. It is decoded from registers only, with no combinational input-to-output path.
  - `divCnt` returns to 0 when `oClkEn` is high and increments otherwise.
- `oCycleCount` increments on every `oClkEn`; 32-bit wrap from 0xFFFFFFFF to 0.
- `oCoreRst = (state==HOLD)`.

## Timing
- Reset values: state=HOLD, `oCoreRst`=1, `oClkEn`=0, `oStepDone`=0, `oState`=0, `oCycleCount`=0, all internal counters 0.
- `oCoreRst` stays high for exactly `ResetHoldCycles` cycles after the first edge with `iRst` sampled low.
- HALT to RUN or STEP: state changes at the edge where `iRun` or `iStep` is sampled. The first `oClkEn` appears `divLat` cycles after entry, and in the entry cycle itself when `iDiv=0`.
- With `iDiv=0`, `oClkEn` is continuously high in RUN.
- RUN to HALT: `oClkEn` is low in the first HALT cycle. No partial or extra enable is produced.
- A step of N enables with divider D occupies N·(D+1) cycles in STEP. `oStepDone` is high in the first HALT cycle after the burst.
- `iRst` in any state:
  - Next edge enters HOLD with all outputs at reset values.
  - An in-flight step is aborted and no `oStepDone` is produced.
  - `oCycleCount` clears.

## Structure
- Shared package `clk_ctrl_pkg` holds:
  - `clk_state_e`, a 2-bit state typedef with the encodings above;
  - `CYCLE_CNT_W = 32`;
  - `STEP_CNT_W = 8`.
- Sub-module `clk_en_divider` contains the divider: `divCnt`, `divLat`, load/clear on entry, and the `oClkEn` decode. The FSM, hold counter, step counter and cycle counter stay in the top.

## Test plan
- Reset release, `ResetHoldCycles=16`: `oCoreRst` is high for exactly 16 cycles after `iRst` falls. `oState` is 0 then 1; `oClkEn` is never high.
- `iRun=1`, `iDiv=0`, held for 10 cycles, then `iRun=0`: 10 consecutive `oClkEn` pulses, `oCycleCount=10`, and `oState` returns to 1.
- Step with `iStepCount=3`, `iDiv=2`: `oClkEn` appears on cycles 2, 5 and 8 after entry. `oStepDone` pulses once on cycle 9 and `oCycleCount` increases by 3.
- `iStepCount=0`: exactly one enable and one `oStepDone`. `iStep` pulses sent during the burst produce no extra steps.
- `iRst` asserted mid-step, after 1 of 4 enables: enters HOLD, no `oStepDone`, `oCycleCount=0`.
- `oCycleCount` forced to 0xFFFFFFFE via backdoor, then 3 enables in RUN: counter reads 0xFFFFFFFF, 0, 1.
